// File: rtl/fetch_decode_hazard_reg.sv
// IF/ID pipeline register with load-use hazard detection, branch squash
// and saturating stall/flush performance counters.
module fetch_decode_hazard_reg #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      InstructionIn,
  input  logic [31:0]      PCAddrIn,
  input  logic             IDEX_MemReadIn,
  input  logic [4:0]       IDEX_rtIn,
  input  logic             BranchTakenIn,
  output logic [31:0]      InstructionOut,
  output logic [31:0]      PCAddrOut,
  output logic             ValidOut,
  output logic             PCWriteOut,
  output logic             BubbleOut,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    ActLoad,
    ActStall,
    ActFlush
  } actionT;

  logic [5:0] opField;
  logic [4:0] rsField;
  logic [4:0] rtField;
  logic       usesRt;
  logic       hazard;
  actionT     action;

  assign opField = InstructionOut[31:26];
  assign rsField = InstructionOut[25:21];
  assign rtField = InstructionOut[20:16];

  always_comb begin
    usesRt = 1'b0;
    case (opField)
      6'h00, 6'h04, 6'h05, 6'h2B: usesRt = 1'b1;
      default:                    usesRt = 1'b0;
    endcase
  end

  // Writes to $zero are discarded, so an rt of zero never needs a stall.
  always_comb begin
    hazard = ValidOut & IDEX_MemReadIn & (IDEX_rtIn != 5'd0) &
             ((IDEX_rtIn == rsField) | (usesRt & (IDEX_rtIn == rtField)));
  end

  always_comb begin
    PCWriteOut = ~hazard | BranchTakenIn;
    BubbleOut  = hazard | BranchTakenIn;
  end

  always_comb begin
    action = ActLoad;
    if (BranchTakenIn) begin
      action = ActFlush;
    end else if (hazard) begin
      action = ActStall;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      InstructionOut <= NOP_WORD;
      PCAddrOut      <= '0;
      ValidOut       <= 1'b0;
      StallCount     <= '0;
      FlushCount     <= '0;
    end else begin
      case (action)
        ActFlush: begin
          InstructionOut <= NOP_WORD;
          PCAddrOut      <= PCAddrIn;
          ValidOut       <= 1'b0;
          if (FlushCount != '1) begin
            FlushCount <= FlushCount + 1'b1;
          end
        end
        ActStall: begin
          if (StallCount != '1) begin
            StallCount <= StallCount + 1'b1;
          end
        end
        default: begin
          InstructionOut <= InstructionIn;
          PCAddrOut      <= PCAddrIn;
          ValidOut       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_hazard_reg.sv
// Scoreboard bench for fetch_decode_hazard_reg: stimulus queues expected
// outputs, a monitor process pops and compares them against the DUT.
module tb_fetch_decode_hazard_reg;

  localparam int unsigned CNT_W = 2;

  logic             Clk;
  logic             Rst_n;
  logic [31:0]      InstructionIn;
  logic [31:0]      PCAddrIn;
  logic             IDEX_MemReadIn;
  logic [4:0]       IDEX_rtIn;
  logic             BranchTakenIn;
  logic [31:0]      InstructionOut;
  logic [31:0]      PCAddrOut;
  logic             ValidOut;
  logic             PCWriteOut;
  logic             BubbleOut;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  fetch_decode_hazard_reg #(
    .CNT_W   (CNT_W),
    .NOP_WORD(32'h00000000)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .InstructionIn (InstructionIn),
    .PCAddrIn      (PCAddrIn),
    .IDEX_MemReadIn(IDEX_MemReadIn),
    .IDEX_rtIn     (IDEX_rtIn),
    .BranchTakenIn (BranchTakenIn),
    .InstructionOut(InstructionOut),
    .PCAddrOut     (PCAddrOut),
    .ValidOut      (ValidOut),
    .PCWriteOut    (PCWriteOut),
    .BubbleOut     (BubbleOut),
    .StallCount    (StallCount),
    .FlushCount    (FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string            name;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic             valid;
    logic             pcw;
    logic             bubble;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } expT;

  expT sbq[$];
  int  nChecks = 0;
  int  nFails  = 0;

  task automatic expectOut(input string name, input logic [31:0] instr,
                           input logic [31:0] pc, input logic valid,
                           input logic pcw, input logic bubble,
                           input int stall, input int flush);
    expT e;
    e.name   = name;
    e.instr  = instr;
    e.pc     = pc;
    e.valid  = valid;
    e.pcw    = pcw;
    e.bubble = bubble;
    e.stall  = stall[CNT_W-1:0];
    e.flush  = flush[CNT_W-1:0];
    sbq.push_back(e);
    #2;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compares each queued expectation against the settled outputs.
  initial begin
    expT e;
    forever begin
      wait (sbq.size() != 0);
      #1;
      e = sbq.pop_front();
      nChecks++;
      if (InstructionOut !== e.instr || PCAddrOut !== e.pc ||
          ValidOut !== e.valid || PCWriteOut !== e.pcw ||
          BubbleOut !== e.bubble || StallCount !== e.stall ||
          FlushCount !== e.flush) begin
        nFails++;
        $display("FAIL %s: got instr=%h pc=%h v=%b pcw=%b bub=%b sc=%0d fc=%0d, want instr=%h pc=%h v=%b pcw=%b bub=%b sc=%0d fc=%0d",
                 e.name, InstructionOut, PCAddrOut, ValidOut, PCWriteOut,
                 BubbleOut, StallCount, FlushCount, e.instr, e.pc, e.valid,
                 e.pcw, e.bubble, e.stall, e.flush);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
    $fatal(1);
  end

  initial begin
    Rst_n          = 1'b0;
    InstructionIn  = 32'h012A4020;
    PCAddrIn       = 32'h4;
    IDEX_MemReadIn = 1'b0;
    IDEX_rtIn      = 5'd0;
    BranchTakenIn  = 1'b0;

    // Reset held across clock edges with live inputs
    repeat (3) tick();
    expectOut("reset_hold", 32'h0, 32'h0, 0, 1, 0, 0, 0);

    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    expectOut("first_load", 32'h012A4020, 32'h4, 1, 1, 0, 0, 0);

    // add $t0,$t1,$t2 in decode, lw writing $t1 in execute
    InstructionIn  = 32'h11111111;
    PCAddrIn       = 32'h8;
    IDEX_MemReadIn = 1'b1;
    IDEX_rtIn      = 5'd9;
    expectOut("hazard_rs_comb", 32'h012A4020, 32'h4, 1, 0, 1, 0, 0);
    tick();
    expectOut("stall_hold", 32'h012A4020, 32'h4, 1, 0, 1, 1, 0);
    IDEX_MemReadIn = 1'b0;
    expectOut("hazard_clear", 32'h012A4020, 32'h4, 1, 1, 0, 1, 0);
    tick();
    expectOut("load_after_stall", 32'h11111111, 32'h8, 1, 1, 0, 1, 0);

    // beq (0x11111111): rt=17 is a source
    IDEX_MemReadIn = 1'b1;
    IDEX_rtIn      = 5'd17;
    expectOut("hazard_beq_rt", 32'h11111111, 32'h8, 1, 0, 1, 1, 0);

    // lw $t0,0($t1): rt match is not a hazard, rs match is
    IDEX_MemReadIn = 1'b0;
    InstructionIn  = 32'h8D280000;
    PCAddrIn       = 32'hC;
    tick();
    expectOut("load_lw", 32'h8D280000, 32'hC, 1, 1, 0, 1, 0);
    IDEX_MemReadIn = 1'b1;
    IDEX_rtIn      = 5'd8;
    expectOut("lw_rt_nohazard", 32'h8D280000, 32'hC, 1, 1, 0, 1, 0);
    IDEX_rtIn      = 5'd9;
    expectOut("lw_rs_hazard", 32'h8D280000, 32'hC, 1, 0, 1, 1, 0);

    // add $t0,$zero,$zero with IDEX rt=0
    IDEX_MemReadIn = 1'b0;
    InstructionIn  = 32'h00004020;
    PCAddrIn       = 32'h10;
    tick();
    expectOut("load_addzero", 32'h00004020, 32'h10, 1, 1, 0, 1, 0);
    IDEX_MemReadIn = 1'b1;
    IDEX_rtIn      = 5'd0;
    expectOut("rt_zero_nohazard", 32'h00004020, 32'h10, 1, 1, 0, 1, 0);

    // Branch flush
    IDEX_MemReadIn = 1'b0;
    BranchTakenIn  = 1'b1;
    InstructionIn  = 32'hDEADBEEF;
    PCAddrIn       = 32'h14;
    expectOut("flush_comb", 32'h00004020, 32'h10, 1, 1, 1, 1, 0);
    tick();
    BranchTakenIn  = 1'b0;
    expectOut("flush_reg", 32'h0, 32'h14, 0, 1, 0, 1, 1);

    // Invalid slot never stalls
    IDEX_MemReadIn = 1'b1;
    IDEX_rtIn      = 5'd9;
    expectOut("invalid_nohazard", 32'h0, 32'h14, 0, 1, 0, 1, 1);

    // Simultaneous hazard and branch: flush wins
    IDEX_MemReadIn = 1'b0;
    InstructionIn  = 32'h012A4020;
    PCAddrIn       = 32'h18;
    tick();
    expectOut("load_pre_both", 32'h012A4020, 32'h18, 1, 1, 0, 1, 1);
    IDEX_MemReadIn = 1'b1;
    IDEX_rtIn      = 5'd10;
    BranchTakenIn  = 1'b1;
    InstructionIn  = 32'hDEADBEEF;
    PCAddrIn       = 32'h1C;
    expectOut("both_comb", 32'h012A4020, 32'h18, 1, 1, 1, 1, 1);
    tick();
    BranchTakenIn  = 1'b0;
    IDEX_MemReadIn = 1'b0;
    expectOut("both_reg", 32'h0, 32'h1C, 0, 1, 0, 1, 2);

    // Stall counter saturation
    InstructionIn  = 32'h012A4020;
    PCAddrIn       = 32'h20;
    tick();
    expectOut("load_pre_sat", 32'h012A4020, 32'h20, 1, 1, 0, 1, 2);
    IDEX_MemReadIn = 1'b1;
    IDEX_rtIn      = 5'd9;
    InstructionIn  = 32'hCAFEF00D;
    PCAddrIn       = 32'h24;
    for (int i = 0; i < 5; i++) begin
      tick();
      expectOut($sformatf("stall_sat_%0d", i), 32'h012A4020, 32'h20, 1, 0, 1,
                (i + 2 > 3) ? 3 : i + 2, 2);
    end

    // Flush counter saturation
    BranchTakenIn = 1'b1;
    tick();
    expectOut("flush_to_max", 32'h0, 32'h24, 0, 1, 1, 3, 3);
    tick();
    BranchTakenIn = 1'b0;
    expectOut("flush_sat", 32'h0, 32'h24, 0, 1, 0, 3, 3);

    // Asynchronous reset pulse between clock edges
    IDEX_MemReadIn = 1'b0;
    InstructionIn  = 32'h012A4020;
    PCAddrIn       = 32'h28;
    tick();
    expectOut("load_pre_rst", 32'h012A4020, 32'h28, 1, 1, 0, 3, 3);
    @(negedge Clk);
    #1;
    Rst_n = 1'b0;
    expectOut("async_reset", 32'h0, 32'h0, 0, 1, 0, 0, 0);
    Rst_n = 1'b1;
    InstructionIn = 32'h8D280000;
    PCAddrIn      = 32'h2C;
    tick();
    expectOut("load_after_rst", 32'h8D280000, 32'h2C, 1, 1, 0, 0, 0);

    for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
      #1;
    end
    if (sbq.size() != 0) begin
      nFails++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fetch_decode_hazard_reg.md
Name: fetch_decode_hazard_reg

Overview:
- IF/ID pipeline register, directly upstream of the decode/execute register. It holds the fetched instruction and PC+4 for the decode stage.
- Contains load-use hazard detection. On a hazard it stalls the PC and this register, and requests a bubble into the decode/execute register.
- Squashes the decode-stage instruction when a branch resolves taken in execute.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of the StallCount and FlushCount performance counters.
- NOP_WORD, 32'h00000000, instruction word loaded on flush and on reset.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- InstructionIn  in  32  instruction word from instruction memory.
- PCAddrIn  in  32  PC+4 from the fetch stage.
- IDEX_MemReadIn  in  1  MemRead control currently held in the decode/execute register.
- IDEX_rtIn  in  5  rt field currently held in the decode/execute register.
- BranchTakenIn  in  1  branch resolved taken in execute this cycle.
- InstructionOut  out  32  registered instruction to decode.
- PCAddrOut  out  32  registered PC+4 to decode.
- ValidOut  out  1  registered; InstructionOut is a real instruction.
- PCWriteOut  out  1  combinational; 1 allows the PC to update.
- BubbleOut  out  1  combinational; 1 forces zero controls into the decode/execute register.
- StallCount  out  CNT_W  registered; number of load-use stall cycles.
- FlushCount  out  CNT_W  registered; number of flush events.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - InstructionOut=NOP_WORD, PCAddrOut=0, ValidOut=0, StallCount=0, FlushCount=0.
  - These values hold while Rst_n=0, regardless of Clk.
- Field decode, from the registered InstructionOut:
  - rs=[25:21], rt=[20:16], op=[31:26].
  - usesRt=1 when op is 6'h00 (R-type), 6'h04 (beq), 6'h05 (bne) or 6'h2B (sw).
- Hazard (combinational):
  - Hazard = ValidOut & IDEX_MemReadIn & (IDEX_rtIn!=0) & ((IDEX_rtIn==rs) | (usesRt & IDEX_rtIn==rt)).
- Combinational outputs:
  - PCWriteOut = ~Hazard | BranchTakenIn.
  - BubbleOut = Hazard | BranchTakenIn.
- Register update at posedge Clk, with priority Flush > Stall > Load:
  - Flush (BranchTakenIn=1): InstructionOut<=NOP_WORD, ValidOut<=0, PCAddrOut<=PCAddrIn. FlushCount increments, saturating at all-ones.
  - Stall (Hazard=1, BranchTakenIn=0): all pipeline outputs hold. StallCount increments, saturating.
  - Load (otherwise): InstructionOut<=InstructionIn, PCAddrOut<=PCAddrIn, ValidOut<=1.
- Latency: 1 cycle from In to Out on a Load.
- Simultaneous hazard and branch: the flush wins. Only FlushCount increments; StallCount does not.
- A stall lasts exactly one cycle. The bubble clears IDEX_MemReadIn on the next edge, so Hazard drops without any internal state.
- rt=0 destination never triggers a stall, since writes to $zero are discarded.
- Invalid slot (ValidOut=0) never triggers a stall.
- Counters saturate and never wrap. They are cleared only by reset.
- Reset released mid-stream: the first edge after Rst_n rises performs a normal Load.

Test Plan:
- Reset, then Load: hold Rst_n=0 and toggle Clk; then release and apply InstructionIn=32'h012A4020, PCAddrIn=32'h4. Required: all outputs at reset values during reset. One edge after release, InstructionOut=32'h012A4020, PCAddrOut=4, ValidOut=1.
- Load-use stall: InstructionOut=add $t0,$t1,$t2 (rs=9), IDEX_MemReadIn=1, IDEX_rtIn=9. Required: PCWriteOut=0 and BubbleOut=1. After the edge, outputs are unchanged and StallCount=1. With IDEX_MemReadIn=0 on the next edge, a Load occurs.
- Non-hazards:
  - lw $t0,0($t1) in decode with IDEX_rtIn=8 (rt match, but usesRt=0) gives Hazard=0.
  - IDEX_rtIn=0 with a matching field gives Hazard=0.
  - ValidOut=0 gives Hazard=0.
- Branch flush: BranchTakenIn=1 with InstructionIn=32'hDEADBEEF. Required: after the edge, InstructionOut=0, ValidOut=0, FlushCount=1, PCWriteOut=1.
- Simultaneous hazard and branch: apply the hazard condition and BranchTakenIn=1 together. Required: flush occurs, StallCount is unchanged, FlushCount increments.
- Saturation: with CNT_W=2, apply 5 stall cycles. Required: StallCount ends at 3. Then apply an asynchronous mid-cycle Rst_n pulse. Required: counters clear immediately, without waiting for a Clk edge.
